// File: rtl/baud_tick_ctrl.sv
// baud_tick_ctrl: UART timing controller in the CLK_50M domain.
// Produces oversample (os_tick), TX bit (tx_tick) and RX mid-bit (rx_tick)
// enable pulses from a runtime-programmable divisor. New divisors arrive
// through a valid/ready handshake and take effect only on a TX bit boundary.
// Optional build macro: CFG_RANGE_CHECK_EN (reject divisors below MIN_DIV
// and flag them on cfg_err instead of clamping).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ticks stopped, counters held at 0, pending divisor applies at once
// RUN   | os/tx/rx phase counters advance, pending divisor waits for tx_tick
module baud_tick_ctrl #(
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned OVS     = 16,
  parameter int unsigned DEF_DIV = 26,
  parameter int unsigned MIN_DIV = 1
) (
  input  logic             CLK_50M,
  input  logic             RST_N,
  input  logic             enable,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             rx_sync,
  output logic             os_tick,
  output logic             tx_tick,
  output logic             rx_tick,
  output logic             running,
  output logic             cfg_err
);

  localparam int unsigned      PH_W    = (OVS > 1) ? $clog2(OVS) : 1;
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(OVS - 1);
  localparam logic [PH_W-1:0]  PH_MID  = PH_W'(OVS / 2 - 1);
  localparam logic [DIV_W-1:0] DIV_DEF = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(MIN_DIV);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_pend_div;
  logic             r_pending;
  logic [DIV_W-1:0] r_os_cnt;
  logic [PH_W-1:0]  r_tx_ph;
  logic [PH_W-1:0]  r_rx_ph;
  logic             r_os_tick;
  logic             r_tx_tick;
  logic             r_rx_tick;
  logic             r_running;
  logic             r_cfg_ready;

  state_t           w_state_nxt;
  logic [DIV_W-1:0] w_div_nxt;
  logic [DIV_W-1:0] w_pend_div_nxt;
  logic             w_pending_nxt;
  logic [DIV_W-1:0] w_os_cnt_nxt;
  logic [PH_W-1:0]  w_tx_ph_nxt;
  logic [PH_W-1:0]  w_rx_ph_nxt;
  logic             w_os_tick_nxt;
  logic             w_tx_tick_nxt;
  logic             w_rx_tick_nxt;
  logic             w_cfg_ready_nxt;

  logic             w_os_wrap;
  logic             w_tx_wrap;
  logic             w_accept;
  logic             w_div_legal;
  logic             w_apply;

  // Terminal counts and handshake qualifiers shared by the next-state logic.
  // The bit boundary is evaluated even while enable is falling so a pending
  // divisor still lands on the boundary it was waiting for.
  assign w_os_wrap   = (r_state == ST_RUN) && (r_os_cnt == r_div);
  assign w_tx_wrap   = w_os_wrap && (r_tx_ph == PH_LAST);
  assign w_accept    = cfg_valid && r_cfg_ready;
  assign w_div_legal = (cfg_div >= DIV_MIN);
  assign w_apply     = r_pending && ((r_state == ST_IDLE) || w_tx_wrap);

`ifdef CFG_RANGE_CHECK_EN
  logic r_cfg_err;
  logic w_cfg_err_nxt;
`endif

  // Next-state, counter and registered-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_div_nxt       = r_div;
    w_pend_div_nxt  = r_pend_div;
    w_pending_nxt   = r_pending;
    w_os_cnt_nxt    = r_os_cnt;
    w_tx_ph_nxt     = r_tx_ph;
    w_rx_ph_nxt     = r_rx_ph;
    w_os_tick_nxt   = 1'b0;
    w_tx_tick_nxt   = 1'b0;
    w_rx_tick_nxt   = 1'b0;
    w_cfg_ready_nxt = r_cfg_ready;
`ifdef CFG_RANGE_CHECK_EN
    w_cfg_err_nxt   = r_cfg_err;
`endif

    case (r_state)
      ST_IDLE: begin
        if (enable) begin
          w_state_nxt  = ST_RUN;
          w_os_cnt_nxt = '0;
          w_tx_ph_nxt  = '0;
          w_rx_ph_nxt  = '0;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          w_state_nxt  = ST_IDLE;
          w_os_cnt_nxt = '0;
          w_tx_ph_nxt  = '0;
          w_rx_ph_nxt  = '0;
        end else if (w_os_wrap) begin
          w_os_cnt_nxt  = '0;
          w_os_tick_nxt = 1'b1;
          w_tx_tick_nxt = w_tx_wrap;
          w_tx_ph_nxt   = (r_tx_ph == PH_LAST) ? '0 : r_tx_ph + 1'b1;
          // A start-bit realign outranks the mid-bit tick it coincides with.
          if (rx_sync) begin
            w_rx_ph_nxt = '0;
          end else begin
            w_rx_tick_nxt = (r_rx_ph == PH_MID);
            w_rx_ph_nxt   = (r_rx_ph == PH_LAST) ? '0 : r_rx_ph + 1'b1;
          end
        end else begin
          w_os_cnt_nxt = r_os_cnt + 1'b1;
          if (rx_sync) begin
            w_rx_ph_nxt = '0;
          end
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_os_cnt_nxt = '0;
        w_tx_ph_nxt  = '0;
        w_rx_ph_nxt  = '0;
      end
    endcase

    // cfg_ready mirrors !pending, so accept and apply never coincide.
    if (w_apply) begin
      w_div_nxt       = r_pend_div;
      w_pending_nxt   = 1'b0;
      w_cfg_ready_nxt = 1'b1;
      w_os_cnt_nxt    = '0;
    end else if (w_accept) begin
`ifdef CFG_RANGE_CHECK_EN
      if (w_div_legal) begin
        w_pend_div_nxt  = cfg_div;
        w_pending_nxt   = 1'b1;
        w_cfg_ready_nxt = 1'b0;
        w_cfg_err_nxt   = 1'b0;
      end else begin
        w_cfg_err_nxt   = 1'b1;
      end
`else
      w_pend_div_nxt  = w_div_legal ? cfg_div : DIV_MIN;
      w_pending_nxt   = 1'b1;
      w_cfg_ready_nxt = 1'b0;
`endif
    end
  end

  // State, counters and output flops; reset drops any pending divisor.
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= ST_IDLE;
      r_div       <= DIV_DEF;
      r_pend_div  <= DIV_DEF;
      r_pending   <= 1'b0;
      r_os_cnt    <= '0;
      r_tx_ph     <= '0;
      r_rx_ph     <= '0;
      r_os_tick   <= 1'b0;
      r_tx_tick   <= 1'b0;
      r_rx_tick   <= 1'b0;
      r_running   <= 1'b0;
      r_cfg_ready <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_div       <= w_div_nxt;
      r_pend_div  <= w_pend_div_nxt;
      r_pending   <= w_pending_nxt;
      r_os_cnt    <= w_os_cnt_nxt;
      r_tx_ph     <= w_tx_ph_nxt;
      r_rx_ph     <= w_rx_ph_nxt;
      r_os_tick   <= w_os_tick_nxt;
      r_tx_tick   <= w_tx_tick_nxt;
      r_rx_tick   <= w_rx_tick_nxt;
      r_running   <= (w_state_nxt == ST_RUN);
      r_cfg_ready <= w_cfg_ready_nxt;
    end
  end

`ifdef CFG_RANGE_CHECK_EN
  // Sticky illegal-divisor flag, cleared by the next legal accept.
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_cfg_err_nxt;
    end
  end

  assign cfg_err = r_cfg_err;
`else
  assign cfg_err = 1'b0;
`endif

  assign os_tick   = r_os_tick;
  assign tx_tick   = r_tx_tick;
  assign rx_tick   = r_rx_tick;
  assign running   = r_running;
  assign cfg_ready = r_cfg_ready;

endmodule

// File: tb/tb_baud_tick_ctrl.sv
// Directed bench for baud_tick_ctrl: tick periods, divisor handshake and
// boundary apply, RX realignment, enable gating and async reset.
module tb_baud_tick_ctrl;

  logic        CLK_50M;
  logic        RST_N;
  logic        enable;
  logic [15:0] cfg_div;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        rx_sync;
  logic        os_tick;
  logic        tx_tick;
  logic        rx_tick;
  logic        running;
  logic        cfg_err;

  int n_tests = 0;
  int n_fail  = 0;
  int n;
  int cnt;

  baud_tick_ctrl #(
    .DIV_W  (16),
    .OVS    (16),
    .DEF_DIV(26),
    .MIN_DIV(1)
  ) dut (
    .CLK_50M  (CLK_50M),
    .RST_N    (RST_N),
    .enable   (enable),
    .cfg_div  (cfg_div),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .rx_sync  (rx_sync),
    .os_tick  (os_tick),
    .tx_tick  (tx_tick),
    .rx_tick  (rx_tick),
    .running  (running),
    .cfg_err  (cfg_err)
  );

  initial CLK_50M = 1'b0;
  always #5 CLK_50M = ~CLK_50M;

  task automatic tick();
    @(posedge CLK_50M);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic sel(input int which);
    case (which)
      0:       return os_tick;
      1:       return tx_tick;
      default: return rx_tick;
    endcase
  endfunction

  // Clocks until the selected tick is seen; -1 if the budget runs out.
  task automatic wait_for(input int which, input int budget, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (sel(which) !== 1'b1 && cycles < budget);
    if (sel(which) !== 1'b1) cycles = -1;
  endtask

  initial begin
    RST_N     = 1'b1;
    enable    = 1'b0;
    cfg_div   = 16'd0;
    cfg_valid = 1'b0;
    rx_sync   = 1'b0;
    #3 RST_N  = 1'b0;
    repeat (3) tick();

    chk("rst_os_tick",   os_tick,   1'b0);
    chk("rst_tx_tick",   tx_tick,   1'b0);
    chk("rst_rx_tick",   rx_tick,   1'b0);
    chk("rst_running",   running,   1'b0);
    chk("rst_cfg_ready", cfg_ready, 1'b1);
    chk("rst_cfg_err",   cfg_err,   1'b0);

    // Default divisor: 27-clock os_tick, 432-clock bit.
    RST_N  = 1'b1;
    enable = 1'b1;
    tick();
    chk("run_entry", running, 1'b1);
    wait_for(0, 2000, n); chk("first_os", n, 27);
    wait_for(0, 2000, n); chk("os_period", n, 27);
    wait_for(1, 2000, n); chk("first_tx_rest", n, 378);
    wait_for(1, 2000, n); chk("tx_period", n, 432);
    tick();
    chk("tx_one_cycle", tx_tick, 1'b0);

    // Mid-bit divisor 4: current bit unchanged, then 5/80 clocks.
    repeat (99) tick();
    cfg_div   = 16'd4;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("cfg_ready_drop", cfg_ready, 1'b0);
    wait_for(1, 2000, n); chk("bit_not_shortened", n, 331);
    wait_for(0, 2000, n); chk("os_after_apply", n, 5);
    chk("cfg_ready_back", cfg_ready, 1'b1);
    wait_for(1, 2000, n); chk("tx_rest_div4", n, 75);
    wait_for(1, 2000, n); chk("tx_period_div4", n, 80);

    // Back to 26, applied on the next 80-clock boundary.
    cfg_div   = 16'd26;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    wait_for(1, 2000, n); chk("tx_before_restore", n, 79);
    wait_for(1, 2000, n); chk("tx_period_restored", n, 432);

    // rx_sync 100 clocks after a boundary (os_cnt=19): 8th os_tick is 196 on.
    repeat (100) tick();
    rx_sync = 1'b1;
    tick();
    rx_sync = 1'b0;
    wait_for(2, 2000, n); chk("rx_after_sync", n, 196);
    wait_for(2, 2000, n); chk("rx_period", n, 432);

    // rx_sync on the rx_tick edge: tick suppressed, os_tick still fires.
    repeat (431) tick();
    rx_sync = 1'b1;
    tick();
    rx_sync = 1'b0;
    chk("sync_wins_rx", rx_tick, 1'b0);
    chk("sync_keeps_os", os_tick, 1'b1);
    wait_for(2, 2000, n); chk("rx_after_coincident_sync", n, 216);

    // Enable dropped mid-bit, then re-enabled.
    repeat (50) tick();
    enable = 1'b0;
    tick();
    chk("idle_running", running, 1'b0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (os_tick || tx_tick || rx_tick) cnt++;
      tick();
    end
    chk("idle_no_ticks", cnt, 0);
    enable = 1'b1;
    tick();
    chk("reenter_running", running, 1'b1);
    wait_for(0, 2000, n); chk("reenter_first_os", n, 27);
    wait_for(1, 2000, n); chk("reenter_tx_restart", n, 405);

    // Divisor 0 offered on a boundary.
    cfg_div   = 16'd0;
    cfg_valid = 1'b1;
    tick();
`ifdef CFG_RANGE_CHECK_EN
    chk("div0_err_set", cfg_err, 1'b1);
    chk("div0_ready_kept", cfg_ready, 1'b1);
    cfg_div = 16'd10;
    tick();
    cfg_valid = 1'b0;
    chk("div10_err_clr", cfg_err, 1'b0);
    chk("div10_ready_drop", cfg_ready, 1'b0);
    wait_for(1, 2000, n); chk("div0_unchanged_bit", n, 430);
    wait_for(0, 2000, n); chk("os_div10", n, 11);
`else
    cfg_valid = 1'b0;
    chk("div0_err_tied", cfg_err, 1'b0);
    chk("div0_ready_drop", cfg_ready, 1'b0);
    wait_for(1, 2000, n); chk("div0_bit_before_apply", n, 431);
    wait_for(0, 2000, n); chk("os_clamped", n, 2);
    chk("clamp_err_tied", cfg_err, 1'b0);
`endif

    // Async reset mid-bit with a divisor pending.
    cfg_div   = 16'd7;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("pend7_ready_drop", cfg_ready, 1'b0);
    repeat (3) tick();
    #2 RST_N = 1'b0;
    #1;
    chk("async_rst_running", running, 1'b0);
    chk("async_rst_ready",   cfg_ready, 1'b1);
    chk("async_rst_os",      os_tick, 1'b0);
    chk("async_rst_err",     cfg_err, 1'b0);
    @(posedge CLK_50M);
    #1;
    RST_N = 1'b1;
    tick();
    chk("post_rst_running", running, 1'b1);
    wait_for(0, 2000, n); chk("post_rst_os", n, 27);
    wait_for(1, 2000, n); chk("post_rst_tx", n, 405);
    wait_for(0, 2000, n); chk("pending_lost", n, 27);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/baud_tick_ctrl.md
Name: baud_tick_ctrl

Overview:
- Timing controller for the UART datapath. Replaces the fixed-ratio clock chain with enable-qualified tick pulses in the CLK_50M domain.
- Generates an oversample tick, a TX bit tick and a mid-bit RX sample tick from a runtime-programmable divisor.
- Accepts divisor updates via valid/ready handshake and applies them only on a TX bit boundary.
- Realigns RX sample phase on request from the receiver's start-bit detector.

Parameters:
DIV_W, 16, width of divisor register/counter
OVS, 16, oversample ticks per bit (even, >=4)
DEF_DIV, 26, reset divisor; os_tick period = DEF_DIV+1 clocks (50 MHz/27/16 ≈ 115200 baud)
MIN_DIV, 1, smallest legal divisor

Ports:
CLK_50M  input  1  system clock, all logic on posedge
RST_N  input  1  asynchronous active-low reset
enable  input  1  level; 1 = run tick generation
cfg_div  input  DIV_W  new divisor (clocks per os_tick minus 1)
cfg_valid  input  1  divisor offer
cfg_ready  output  1  controller can accept a divisor
rx_sync  input  1  one-cycle pulse: restart RX bit phase (start-bit edge seen)
os_tick  output  1  one-cycle oversample pulse
tx_tick  output  1  one-cycle pulse, one per bit period
rx_tick  output  1  one-cycle pulse at RX mid-bit
running  output  1  1 while in RUN state
cfg_err  output  1  sticky illegal-divisor flag (see Optional Feature)

Behaviour:
- Reset (RST_N=0, async): state IDLE; div_reg=DEF_DIV; os_cnt, tx_ph, rx_ph = 0; pending=0; all ticks 0; running=0; cfg_ready=1; cfg_err=0.
- States: IDLE, RUN. IDLE->RUN on the first clock with enable=1. RUN->IDLE on the first clock with enable=0. On either transition clear os_cnt, tx_ph, rx_ph. running=1 exactly in RUN. All outputs registered.
- RUN, os counter: os_cnt increments each clock. When os_cnt==div_reg: os_tick=1 next cycle and os_cnt wraps to 0. First os_tick occurs div_reg+1 clocks after entering RUN.
- tx_ph counts os_ticks modulo OVS. tx_tick asserts together with the os_tick that wraps tx_ph from OVS-1 to 0. Period = (div_reg+1)*OVS clocks.
- rx_ph counts os_ticks modulo OVS. rx_tick asserts together with the os_tick on which rx_ph reaches OVS/2-1. After rx_sync, the first rx_tick comes OVS/2 os_ticks later, then one every OVS.
- rx_sync in RUN: rx_ph=0, os_cnt untouched.
- rx_sync coincident with the rx_tick condition: sync wins; rx_ph=0, no rx_tick.
- rx_sync in IDLE: ignored.
- Config handshake: transfer on cfg_valid&&cfg_ready. The value is latched into pend_div, pending=1, cfg_ready=0 from the next cycle.
- Apply pending value in IDLE: on the next clock.
- Apply pending value in RUN: on the clock where tx_tick is generated. div_reg<=pend_div and os_cnt restarts at 0, so no bit is shortened or stretched mid-period.
- After apply: pending=0; cfg_ready=1 the following cycle.
- Apply coincident with enable falling: apply happens and state goes IDLE.
- cfg_div < MIN_DIV (without macro): clamped to MIN_DIV on accept.
- Reset mid-operation: immediate return to reset values. A pending divisor is lost.

Optional Feature:
- Macro CFG_RANGE_CHECK_EN.
- Defined: an accepted cfg_div < MIN_DIV completes the handshake but is discarded (pending stays 0, div_reg unchanged) and sets cfg_err=1. cfg_err clears on the next accepted legal divisor or on reset.
- Undefined: out-of-range values are clamped to MIN_DIV and cfg_err is tied 0.

Test Plan:
- Reset release, enable=1, defaults: os_tick every 27 clocks; first tx_tick 432 clocks after RUN entry, then every 432; running=1.
- Program cfg_div=4 mid-bit in RUN: cfg_ready drops next cycle; current bit stays 432 clocks; from the boundary tx_tick period = 80 clocks, os_tick = 5; cfg_ready returns 1.
- rx_sync pulse in RUN with div=26: first rx_tick 8 os_ticks (216±26 clocks) later, then every 432 clocks; rx_sync on the rx_tick cycle suppresses that tick.
- enable dropped mid-bit: next cycle running=0, no ticks. Re-enable: first os_tick after 27 clocks, tx_ph restarted.
- cfg_div=0 offered: undefined macro -> os_tick every 2 clocks, cfg_err=0; CFG_RANGE_CHECK_EN -> divisor unchanged (27-clock os_tick), cfg_err=1, cleared by a later cfg_div=10.
- Assert RST_N low asynchronously mid-bit with pending config: all outputs reset instantly; div_reg=26; cfg_ready=1.
